// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Brief    : Shared fault codes, FSM state encoding and helpers for the
//            instruction memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  localparam int FLT_W = 3;

  localparam logic [FLT_W-1:0] FLT_OK           = 3'd0;
  localparam logic [FLT_W-1:0] FLT_MISALIGNED   = 3'd1;
  localparam logic [FLT_W-1:0] FLT_OUT_OF_RANGE = 3'd2;
  localparam logic [FLT_W-1:0] FLT_UNWRITTEN    = 3'd3;
  localparam logic [FLT_W-1:0] FLT_PARITY       = 3'd4;
  localparam logic [FLT_W-1:0] FLT_BUSY         = 3'd5;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Number of byte-offset bits inside one word of data_w bits.
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_if
// Brief    : Fetch-side read channel and loader-side write channel of the
//            instruction memory. The IMEM_PARITY_EN macro adds inj_par_err.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import imem_pkg::*;

  logic                ready;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic [FLT_W-1:0]    rd_fault;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
`ifdef IMEM_PARITY_EN
  logic                inj_par_err;
`endif
  logic                wr_ack;
  logic                wr_err;

  modport master (
    input  ready,
    output rd_req, rd_addr,
    input  rd_valid, rd_data, rd_fault,
    output wr_en, wr_addr, wr_data,
`ifdef IMEM_PARITY_EN
    output inj_par_err,
`endif
    input  wr_ack, wr_err
  );

  modport slave (
    output ready,
    input  rd_req, rd_addr,
    output rd_valid, rd_data, rd_fault,
    input  wr_en, wr_addr, wr_data,
`ifdef IMEM_PARITY_EN
    input  inj_par_err,
`endif
    output wr_ack, wr_err
  );

endinterface
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module   : imem_array
// Brief    : DEPTH x WIDTH storage, one write port and one registered read
//            port. A read and write to the same word in one cycle returns the
//            old contents (read-first).
// Revision : 1.0 - initial release
// ============================================================================
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32,
  parameter int IDX_W = 7
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [IDX_W-1:0] i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic [IDX_W-1:0] i_raddr,
  output logic      [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port plus registered read; non-blocking update gives read-first.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/imem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_ctrl
// Brief    : Instruction memory with post-reset clearing sweep, pipelined
//            req/valid reads with fault codes, and a checked load port.
//            Optional macro IMEM_PARITY_EN adds per-word even parity and the
//            inj_par_err error-injection input.
// Revision : 1.0 - initial release
// ============================================================================
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  wire logic clk,
  input  wire logic reset,
  imem_if.slave     bus
);

  localparam int c_BYTES = DATA_W / 8;
  localparam int c_OFF_W = off_bits(DATA_W);
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int c_MEM_W = DATA_W + 1;
`else
  localparam int c_MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0]  c_OFF_MASK = ADDR_W'(c_BYTES - 1);
  localparam logic [ADDR_W-1:0]  c_DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(DEPTH - 1);

  state_t              r_state, w_state_nxt;
  logic [c_IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [DEPTH-1:0]    r_tag;
  logic                w_ready;

  logic [ADDR_W-1:0]   w_wr_word;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic                w_wr_ok;
  logic                w_wr_commit;

  logic [ADDR_W-1:0]   w_rd_word;
  logic                w_rd_inrange;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic [FLT_W-1:0]    w_rd_flt;

  logic                w_mem_we;
  logic [c_IDX_W-1:0]  w_mem_waddr;
  logic [c_MEM_W-1:0]  w_mem_wdata;
  logic [c_MEM_W-1:0]  w_mem_rdata;

  logic                r_valid;
  logic [FLT_W-1:0]    r_flt;
  logic [FLT_W-1:0]    w_out_flt;
  logic                r_ack;
  logic                r_err;

  // FSM state and sweep index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Sweep advances one word per cycle and parks in READY after the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_INIT: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == c_LAST) begin
          w_state_nxt = ST_READY;
          w_idx_nxt   = '0;
        end
      end
      ST_READY: ;
      default: begin
        w_state_nxt = ST_INIT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_ready = (r_state == ST_READY);

  // Write legality: word index is kept at full address width so huge
  // addresses never alias onto valid words.
  assign w_wr_word   = bus.wr_addr >> c_OFF_W;
  assign w_wr_idx    = w_wr_word[c_IDX_W-1:0];
  assign w_wr_ok     = w_ready && ((bus.wr_addr & c_OFF_MASK) == '0) && (w_wr_word < c_DEPTH_A);
  assign w_wr_commit = bus.wr_en && w_wr_ok && !reset;

  // Storage write mux: sweep clears words, otherwise committed loads.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_idx;
    w_mem_wdata = '0;
    if (r_state == ST_INIT) begin
      w_mem_we = 1'b1;
    end else if (w_wr_commit) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = w_wr_idx;
      w_mem_wdata[DATA_W-1:0] = bus.wr_data;
`ifdef IMEM_PARITY_EN
      w_mem_wdata[DATA_W] = (^bus.wr_data) ^ bus.inj_par_err;
`endif
    end
  end

  // Valid tags: cleared by the sweep, set by committed loads.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_tag[r_idx] <= 1'b0;
    end else if (w_wr_commit) begin
      r_tag[w_wr_idx] <= 1'b1;
    end
  end

  // Read address decode; out-of-range requests read word 0 harmlessly.
  assign w_rd_word    = bus.rd_addr >> c_OFF_W;
  assign w_rd_inrange = (w_rd_word < c_DEPTH_A);
  assign w_rd_idx     = w_rd_inrange ? w_rd_word[c_IDX_W-1:0] : '0;

  // Fault priority evaluated against pre-write tags (read-first).
  always_comb begin
    w_rd_flt = FLT_OK;
    if (!w_ready) begin
      w_rd_flt = FLT_BUSY;
    end else if ((bus.rd_addr & c_OFF_MASK) != '0) begin
      w_rd_flt = FLT_MISALIGNED;
    end else if (!w_rd_inrange) begin
      w_rd_flt = FLT_OUT_OF_RANGE;
    end else if (!r_tag[w_rd_idx]) begin
      w_rd_flt = FLT_UNWRITTEN;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .WIDTH (c_MEM_W),
    .IDX_W (c_IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

  // Response pipeline stage for reads and write acknowledges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_flt   <= FLT_OK;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= bus.rd_req;
      r_flt   <= bus.rd_req ? w_rd_flt : FLT_OK;
      r_ack   <= bus.wr_en && w_wr_ok;
      r_err   <= bus.wr_en && !w_wr_ok;
    end
  end

  // Final fault: parity only downgrades an otherwise clean response.
  always_comb begin
    w_out_flt = r_flt;
`ifdef IMEM_PARITY_EN
    if (r_valid && (r_flt == FLT_OK) &&
        ((^w_mem_rdata[DATA_W-1:0]) != w_mem_rdata[DATA_W])) begin
      w_out_flt = FLT_PARITY;
    end
`endif
  end

  assign bus.ready    = w_ready;
  assign bus.rd_valid = r_valid;
  assign bus.rd_fault = w_out_flt;
  assign bus.rd_data  = (r_valid && (w_out_flt == FLT_OK)) ? w_mem_rdata[DATA_W-1:0] : '0;
  assign bus.wr_ack   = r_ack;
  assign bus.wr_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_ctrl
// Brief    : Directed scenarios plus randomized traffic for imem_ctrl, checked
//            against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_ctrl;
  import imem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int BYTES  = DATA_W / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word contents, written flags, corrupted-parity flags,
  // and the number of sweep cycles still outstanding.
  logic [DATA_W-1:0] m_data [DEPTH];
  bit                m_tag  [DEPTH];
  bit                m_pbad [DEPTH];
  int                m_left = DEPTH;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict, advance the model, compare.
  task automatic cyc(input bit rst_i, input bit req, input logic [31:0] ra,
                     input bit we, input logic [31:0] wa, input logic [31:0] wd,
                     input bit inj);
    logic [FLT_W-1:0]  e_flt;
    logic [DATA_W-1:0] e_dat;
    bit                e_val, e_ack, e_err, wok;
    longint            rw, ww;
    reset       = rst_i;
    bus.rd_req  = req;
    bus.rd_addr = ra;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
`ifdef IMEM_PARITY_EN
    bus.inj_par_err = inj;
`endif
    @(posedge clk);
    rw = longint'(ra) / BYTES;
    ww = longint'(wa) / BYTES;
    e_val = !rst_i && req;
    e_dat = '0;
    if (m_left != 0)               e_flt = FLT_BUSY;
    else if (ra % BYTES != 0)      e_flt = FLT_MISALIGNED;
    else if (rw >= DEPTH)          e_flt = FLT_OUT_OF_RANGE;
    else if (!m_tag[rw])           e_flt = FLT_UNWRITTEN;
`ifdef IMEM_PARITY_EN
    else if (m_pbad[rw])           e_flt = FLT_PARITY;
`endif
    else begin
      e_flt = FLT_OK;
      e_dat = m_data[rw];
    end
    wok   = (m_left == 0) && (wa % BYTES == 0) && (ww < DEPTH);
    e_ack = !rst_i && we && wok;
    e_err = !rst_i && we && !wok;
    if (rst_i) begin
      m_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        m_tag[i]  = 1'b0;
        m_pbad[i] = 1'b0;
      end
    end else begin
      if (e_ack) begin
        m_data[ww] = wd;
        m_tag[ww]  = 1'b1;
        m_pbad[ww] = inj;
      end
      if (m_left > 0) m_left--;
    end
    #1;
    chk("ready", bus.ready, m_left == 0);
    chk("rd_valid", bus.rd_valid, e_val);
    chk("wr_ack", bus.wr_ack, e_ack);
    chk("wr_err", bus.wr_err, e_err);
    if (e_val) begin
      chk("rd_fault", bus.rd_fault, e_flt);
      chk("rd_data", bus.rd_data, e_dat);
    end
    if (rst_i) begin
      chk("rst_fault", bus.rd_fault, FLT_OK);
      chk("rst_data", bus.rd_data, 0);
    end
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit inj);
    cyc(0, 0, 0, 1, a, d, inj);
  endtask

  function automatic logic [31:0] pick();
    int k = int'($urandom_range(0, 19));
    if (k == 0) return 32'hFFFF_FFFC;
    if (k == 1) return 32'(BYTES * $urandom_range(DEPTH, DEPTH + 8));
    if (k <= 3) return 32'(BYTES * $urandom_range(0, DEPTH - 1) + $urandom_range(1, BYTES - 1));
    if (k <= 12) return 32'(BYTES * $urandom_range(0, 15));
    return 32'(BYTES * $urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    logic [31:0] ra, wa, wd;
    bit rq, we, inj, rs;
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0;
      m_tag[i]  = 1'b0;
      m_pbad[i] = 1'b0;
    end
    bus.rd_req = 0; bus.rd_addr = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
`ifdef IMEM_PARITY_EN
    bus.inj_par_err = 0;
`endif

    // Sweep with continuous requests: BUSY until ready, then UNWRITTEN.
    cyc(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) rd(0);

    // Load and read back, including a stored zero word.
    wr(32'h4, 32'h0064_2820, 0);
    wr(32'h8, 32'h0000_0000, 0);
    rd(32'h4); rd(32'h8); rd(32'hC);

    // Alignment and range boundaries.
    rd(32'h6);
    rd(32'h200);
    wr(32'h1FC, 32'h1234_5678, 0);
    wr(32'h200, 32'hDEAD_BEEF, 0);
    rd(32'h1FC);

    // Same-cycle read and write to one word returns the old state.
    cyc(0, 1, 32'h10, 1, 32'h10, 32'hAE01_0000, 0);
    rd(32'h10);

    // Reset mid-sweep, and again after loading in READY.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) rd(32'h4);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) rd(32'h4);
    wr(32'h4, 32'hCAFE_0001, 0);
    rd(32'h4);
    cyc(1, 1, 32'h4, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) rd(32'h4);

`ifdef IMEM_PARITY_EN
    // Injected parity error, then a clean rewrite.
    wr(32'h20, 32'h0BAD_F00D, 1);
    rd(32'h20);
    wr(32'h20, 32'h0BAD_F00D, 0);
    rd(32'h20);
`endif

    // Randomized mixed traffic.
    for (int n = 0; n < 3000; n++) begin
      rs = ($urandom_range(0, 799) == 0);
      rq = ($urandom_range(0, 3) != 0);
      ra = pick();
      we = ($urandom_range(0, 2) == 0);
      wa = ($urandom_range(0, 3) == 0) ? ra : pick();
      wd = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
`ifdef IMEM_PARITY_EN
      inj = ($urandom_range(0, 7) == 0);
`else
      inj = 1'b0;
`endif
      cyc(rs, rq, ra, we, wa, wd, inj);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
